// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed 8-digit display scanner.
package disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = $clog2(NUM_DIGITS);
  localparam int DISP_W     = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] ANODE_RESET = 8'hFE;

  // Active-low one-hot anode pattern for a given digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [SEL_W-1:0] sel);
    return ~(NUM_DIGITS'(1) << sel);
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Host-side load bus and scan outputs of the display scanner.
interface disp_scan_ctrl_if;
  import disp_pkg::*;

  logic                  load;
  logic [DISP_W-1:0]     data_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank_lz;

  logic [DIGIT_W-1:0]    hexnum;
  logic [SEL_W-1:0]      digit_sel;
  logic [NUM_DIGITS-1:0] anode;
  logic                  dp;
  logic                  blank;
  logic                  frame_start;
  logic                  pending;

  modport master (
    output load, data_in, dp_in, blank_lz,
    input  hexnum, digit_sel, anode, dp, blank, frame_start, pending
  );

  modport slave (
    input  load, data_in, dp_in, blank_lz,
    output hexnum, digit_sel, anode, dp, blank, frame_start, pending
  );

endinterface

// File: rtl/disp_scan_ctrl_prescaler.sv
// Free-running divider producing one tick every REFRESH_DIV clocks.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Count 0..REFRESH_DIV-1 and wrap; reset restarts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display scanner with frame-synchronous data commit.
// Loads are parked in pending registers and only reach the display registers
// on the last tick of a frame, so one scanned frame never mixes old and new.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);

  logic                  tick;
  logic                  commit;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      sel_next;
  logic [NUM_DIGITS-1:0] anode_r;
  logic                  fstart;
  logic                  pend_flag;
  logic [DISP_W-1:0]     pend_data;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [DISP_W-1:0]     disp_data;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic                  upper_zero;
  logic                  blank_c;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign sel_next = sel + SEL_W'(1);
  assign commit   = tick && (sel == SEL_W'(NUM_DIGITS - 1));

  // Digit scan: advance the selected digit and its anode together on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= '0;
      anode_r <= ANODE_RESET;
      fstart  <= 1'b0;
    end else begin
      fstart <= commit;
      if (tick) begin
        sel     <= sel_next;
        anode_r <= anode_for(sel_next);
      end
    end
  end

  // Capture loads into pending; move to display only at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_flag <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else if (commit) begin
      // A load landing on the commit edge bypasses pending entirely.
      if (bus.load) begin
        disp_data <= bus.data_in;
        disp_dp   <= bus.dp_in;
      end else if (pend_flag) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      pend_flag <= 1'b0;
    end else if (bus.load) begin
      pend_data <= bus.data_in;
      pend_dp   <= bus.dp_in;
      pend_flag <= 1'b1;
    end
  end

  // Leading-zero blanking: blank when this digit and all above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(sel)) && (disp_data[i*DIGIT_W +: DIGIT_W] != '0)) begin
        upper_zero = 1'b0;
      end
    end
    blank_c = bus.blank_lz && (sel != '0) && upper_zero;
  end

  assign bus.hexnum      = disp_data[sel*DIGIT_W +: DIGIT_W];
  assign bus.dp          = ~disp_dp[sel];
  assign bus.blank       = blank_c;
  assign bus.digit_sel   = sel;
  assign bus.anode       = anode_r;
  assign bus.frame_start = fstart;
  assign bus.pending     = pend_flag;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a short refresh period.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int DIV = 4;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] an;
    logic [3:0] hex;
    logic       dp;
    logic       blank;
  } slot_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpv;
    logic        blz;
    int          slot;
    logic [31:0] exp_hex;
    logic [7:0]  exp_dpn;
    logic [7:0]  exp_blank;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  slot_t sb_q[$];
  logic [7:0] an_q[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      cycle();
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL frame_start_wait actual=none required=pulse_within_40");
    end
  endtask

  task automatic drive_load(input logic [31:0] d, input logic [7:0] p);
    bus.data_in = d;
    bus.dp_in   = p;
    bus.load    = 1'b1;
    cycle();
    bus.load    = 1'b0;
  endtask

  function automatic slot_t mk(input int s, input logic [3:0] h, input logic d, input logic b);
    slot_t r;
    logic [7:0] one;
    one     = 8'h01;
    r.sel   = 3'(s);
    r.an    = ~(one << s);
    r.hex   = h;
    r.dp    = d;
    r.blank = b;
    return r;
  endfunction

  task automatic push_frame(input logic [31:0] hx, input logic [7:0] dpn, input logic [7:0] bl);
    for (int s = 0; s < 8; s++) sb_q.push_back(mk(s, hx[4*s +: 4], dpn[s], bl[s]));
  endtask

  // Called on the frame_start cycle; checks one sample per digit slot.
  task automatic check_frame(input string tag);
    slot_t act, exp;
    for (int s = 0; s < 8; s++) begin
      act = {bus.digit_sel, bus.anode, bus.hexnum, bus.dp, bus.blank};
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_d%0d actual=%0h required=queued_entry", tag, s, act);
      end else begin
        exp = sb_q.pop_front();
        chk($sformatf("%s_d%0d", tag, s), act, exp);
      end
      repeat (DIV) cycle();
    end
  endtask

  initial begin
    bit ok;
    int cnt, bad, saw_a, pos;
    logic [31:0] prev_hex;

    vecs[0] = '{data:32'h12345678, dpv:8'h01, blz:1'b0, slot:3,
                exp_hex:32'h12345678, exp_dpn:8'hFE, exp_blank:8'h00};
    vecs[1] = '{data:32'h000000A0, dpv:8'h00, blz:1'b1, slot:1,
                exp_hex:32'h000000A0, exp_dpn:8'hFF, exp_blank:8'hFC};
    vecs[2] = '{data:32'h00000000, dpv:8'h00, blz:1'b1, slot:2,
                exp_hex:32'h00000000, exp_dpn:8'hFF, exp_blank:8'hFE};
    vecs[3] = '{data:32'h00F00001, dpv:8'h80, blz:1'b1, slot:0,
                exp_hex:32'h00F00001, exp_dpn:8'h7F, exp_blank:8'hC0};
    vecs[4] = '{data:32'h9ABCDEF0, dpv:8'hA5, blz:1'b1, slot:6,
                exp_hex:32'h9ABCDEF0, exp_dpn:8'h5A, exp_blank:8'h00};

    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.blank_lz = 1'b0;
    rst          = 1'b1;

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", bus.anode, 8'hFE);
    chk("rst_sel", bus.digit_sel, 0);
    chk("rst_hex", bus.hexnum, 0);
    chk("rst_dp", bus.dp, 1);
    chk("rst_blank", bus.blank, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_fs", bus.frame_start, 0);

    rst = 1'b0;
    chk("rel_anode", bus.anode, 8'hFE);
    chk("rel_sel", bus.digit_sel, 0);

    // Anode walk over one frame
    an_q = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    for (int k = 1; k <= 8; k++) begin
      repeat (DIV) cycle();
      chk($sformatf("anode_step%0d", k), bus.anode, an_q.pop_front());
    end
    chk("fs_after_wrap", bus.frame_start, 1);
    cnt = 0;
    for (int c = 0; c < 32; c++) begin
      cycle();
      if (bus.frame_start === 1'b1) cnt++;
    end
    chk("fs_per_frame", cnt, 1);

    // Table-driven load/commit vectors
    prev_hex = 32'h0;
    for (int v = 0; v < 5; v++) begin
      wait_fs(ok);
      repeat (4 * vecs[v].slot) cycle();
      bus.blank_lz = vecs[v].blz;
      push_frame(vecs[v].exp_hex, vecs[v].exp_dpn, vecs[v].exp_blank);
      drive_load(vecs[v].data, vecs[v].dpv);
      pos = 4 * vecs[v].slot + 1;
      chk($sformatf("v%0d_pending_set", v), bus.pending, 1);
      bad = 0;
      ok  = 1'b0;
      for (int t = 0; t < 40; t++) begin
        if (bus.frame_start === 1'b1) begin
          ok = 1'b1;
          break;
        end
        if (bus.hexnum !== prev_hex[4*(pos/4) +: 4]) bad++;
        cycle();
        pos++;
      end
      chk($sformatf("v%0d_reached_fs", v), ok, 1);
      chk($sformatf("v%0d_old_held", v), bad, 0);
      chk($sformatf("v%0d_pending_clr", v), bus.pending, 0);
      check_frame($sformatf("v%0d", v));
      prev_hex = vecs[v].exp_hex;
    end

    // Two loads in one frame: last one wins
    wait_fs(ok);
    bus.blank_lz = 1'b0;
    repeat (4) cycle();
    drive_load(32'hAAAAAAAA, 8'h00);
    repeat (7) cycle();
    drive_load(32'h55555555, 8'h00);
    chk("lw_pending", bus.pending, 1);
    wait_fs(ok);
    chk("lw_pending_clr", bus.pending, 0);
    bad   = 0;
    saw_a = 0;
    for (int c = 0; c < 32; c++) begin
      if (bus.hexnum !== 4'h5) bad++;
      if (bus.hexnum === 4'hA) saw_a++;
      cycle();
    end
    chk("lw_all_five", bad, 0);
    chk("lw_never_a", saw_a, 0);

    // Load on the commit cycle goes straight to display
    repeat (31) cycle();
    chk("cl_sel_before", bus.digit_sel, 7);
    chk("cl_pending_before", bus.pending, 0);
    push_frame(32'h0000BEEF, 8'hFF, 8'h00);
    drive_load(32'h0000BEEF, 8'h00);
    chk("cl_fs", bus.frame_start, 1);
    chk("cl_pending", bus.pending, 0);
    check_frame("beef");

    // Commit with nothing pending keeps the display
    chk("keep_d0", bus.hexnum, 4'hF);
    repeat (12) cycle();
    chk("keep_d3", bus.hexnum, 4'hB);

    // Asynchronous reset mid-frame discards a pending load
    wait_fs(ok);
    repeat (4) cycle();
    drive_load(32'h13572468, 8'hFF);
    chk("ar_pending_set", bus.pending, 1);
    repeat (15) cycle();
    chk("ar_sel_before", bus.digit_sel, 5);
    bus.blank_lz = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_anode", bus.anode, 8'hFE);
    chk("ar_pending", bus.pending, 0);
    chk("ar_sel", bus.digit_sel, 0);
    chk("ar_hex", bus.hexnum, 0);
    chk("ar_dp", bus.dp, 1);
    chk("ar_blank", bus.blank, 0);
    chk("ar_fs", bus.frame_start, 0);
    cycle();
    rst = 1'b0;
    repeat (DIV - 1) cycle();
    chk("ar_first_tick_early", bus.digit_sel, 0);
    cycle();
    chk("ar_first_tick", bus.digit_sel, 1);
    push_frame(32'h0, 8'hFF, 8'hFE);
    bad = 0;
    ok  = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.hexnum !== 4'h0 || bus.pending !== 1'b0) bad++;
      cycle();
    end
    chk("ar_reached_fs", ok, 1);
    chk("ar_zero_hold", bad, 0);
    chk("ar_pending_fs", bus.pending, 0);
    check_frame("ar");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, 50000, clk cycles per digit slot; legal values are >= 2.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-high.
REQ-004 Port: load  in  1  single-cycle strobe that captures data_in and dp_in.
REQ-005 Port: data_in  in  32  eight hex digits; nibble i belongs to digit i (digit 0 = bits 3:0).
REQ-006 Port: dp_in  in  8  per-digit decimal-point enable; 1 = point lit.
REQ-007 Port: blank_lz  in  1  leading-zero blanking enable; sampled live, not captured.
REQ-008 Port: hexnum  out  4  nibble for the currently selected digit, feeds the segment decoder.
REQ-009 Port: digit_sel  out  3  index of the currently selected digit.
REQ-010 Port: anode  out  8  active-low one-hot digit enable.
REQ-011 Port: dp  out  1  active-low decimal point for the current digit.
REQ-012 Port: blank  out  1  high = decoder drives all segments off for this digit.
REQ-013 Port: frame_start  out  1  one-cycle pulse when digit_sel wraps from 7 to 0.
REQ-014 Port: pending  out  1  high while a captured load is waiting to be committed.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick = (count == REFRESH_DIV-1).
REQ-016 On each tick, digit_sel SHALL advance by 1 modulo 8 (7 -> 0).
REQ-017 The commit event SHALL be the tick with digit_sel == 7; frame_start SHALL be high for exactly the cycle after that edge, i.e. the first cycle with digit_sel == 0.
REQ-018 anode SHALL be a register that equals ~(1 << digit_sel) at all times; digit changes to hexnum and anode SHALL happen on the same edge.
REQ-019 On load, data_in and dp_in SHALL be written into the pending registers and pending SHALL be set.
REQ-020 Multiple loads before a commit: the last load wins; no queueing.
REQ-021 At a commit with pending == 1 and no load, the pending registers SHALL be copied into the display registers and pending SHALL be cleared.
REQ-022 Load in the same cycle as a commit: data_in/dp_in SHALL go straight into the display registers and pending SHALL be 0 after that edge.
REQ-023 A commit with pending == 0 SHALL leave the display registers unchanged.
REQ-024 hexnum and dp SHALL be combinational from registered state, with zero latency:
  - hexnum = display[4*digit_sel +: 4]
  - dp = ~display_dp[digit_sel]
REQ-025 blank SHALL be 1 when all of the following hold:
  - blank_lz == 1
  - digit_sel != 0
  - every display nibble at indices digit_sel..7 is zero
  Otherwise blank SHALL be 0; digit 0 is never blanked.
REQ-026 The display registers SHALL change only at a commit, so a displayed frame never mixes old and new values.

Reset
REQ-027 While rst is high, the following outputs and registers SHALL hold these values:
  - prescaler 0, digit_sel 0, anode 8'hFE
  - display and pending data 0, display_dp and pending dp 0
  - pending 0, frame_start 0
  - hexnum 0, dp 1, blank 0
REQ-028 Asserting rst mid-frame SHALL apply REQ-027 immediately without waiting for clk, and SHALL discard any pending load.
REQ-029 After rst is released, the first tick SHALL occur REFRESH_DIV cycles later.

Structure
REQ-030 The shared package disp_pkg SHALL hold NUM_DIGITS = 8, DIGIT_W = 4 and ANODE_RESET = 8'hFE.
REQ-031 The prescaler SHALL be the sub-module refresh_prescaler (REFRESH_DIV parameter, output tick); everything else is flat.

Verification (REFRESH_DIV = 4)
REQ-032 Reset release -> anode FE, digit_sel 0, hexnum 0, dp 1, blank 0, pending 0; anode then steps FD, FB, F7, EF, DF, BF, 7F, FE at 4-cycle intervals; frame_start pulses once per 32 cycles.
REQ-033 load 0x12345678 with dp_in 0x01 at digit_sel 3 -> pending 1 and hexnum stays 0 until the frame_start cycle; in the next frame digit 0 shows 8 with dp 0, digit 7 shows 1 with dp 1; pending returns to 0.
REQ-034 load 0xAAAAAAAA then load 0x55555555 in the same frame -> every digit shows 5 in the next frame; 0xA is never displayed.
REQ-035 load 0x0000BEEF on the commit tick cycle -> pending stays 0; digits 0-3 show F, E, E, B starting at frame_start.
REQ-036 blank_lz 1 with display 0x000000A0 -> digits 7..2 blank 1, digit 1 shows hexnum A with blank 0, digit 0 shows hexnum 0 with blank 0; with display 0x00000000 only digit 0 is unblanked.
REQ-037 rst pulsed at digit_sel 5 with pending 1 -> anode FE and pending 0 immediately; after release the display stays 0 through the next frame_start.
